// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller state encoding and latch-control bundle.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    // One pipeline latch: load enable plus bubble-insert request.
    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t LATCH_ADV   = '{en: 1'b1, flush: 1'b0};
    localparam latch_ctrl_t LATCH_HOLD  = '{en: 1'b0, flush: 1'b0};
    localparam latch_ctrl_t LATCH_BUB   = '{en: 1'b1, flush: 1'b1};
    localparam latch_ctrl_t LATCH_RESET = '{en: 1'b0, flush: 1'b1};

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Pipeline performance counters: stall cycles and branch-flush cycles.
// Both wrap naturally at 2^PERF_CNT_W; the parent gates the increments.
module pipe_perf_cnt
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  stallInc,
    input  logic                  flushInc,
    output logic [PERF_CNT_W-1:0] stallCnt,
    output logic [PERF_CNT_W-1:0] flushCnt
);

    // Count qualified events; synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallInc) stallCnt <= stallCnt + 1'b1;
            if (flushInc) flushCnt <= flushCnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline latch controller: arbitrates halt, data-memory wait,
// branch flush, load-use stall and fetch miss into per-latch enable/flush.
// Optional feature macro: PIPE_PERF_EN adds stall_cnt / flush_cnt outputs.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       hu_stall,
    input  logic       mem_branch,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_en,
    output logic       memwb_flush,
    output logic       halted,
    output logic [1:0] ctrl_state
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    ctrl_state_t state, nextState;
    logic        ihitPend, nextPend;
    logic        pcEn, haltedInt;
    logic        dwait, effIhit;
    latch_ctrl_t ifid, idex, exmem, memwb;

    assign dwait   = (mem_dREN | mem_dWEN) & ~dhit;
    // A fetch that completed while the PC was frozen still counts.
    assign effIhit = ihit | ihitPend;

    // Priority arbitration: reset > halt > dwait > branch > load-use > fetch miss.
    always_comb begin
        // NOTE: every signal gets a default before the if-chain so no path infers a latch.
        pcEn      = 1'b1;
        ifid      = LATCH_ADV;
        idex      = LATCH_ADV;
        exmem     = LATCH_ADV;
        memwb     = LATCH_ADV;
        haltedInt = 1'b0;
        nextState = RUN;
        nextPend  = 1'b0;
        if (RST) begin
            pcEn  = 1'b0;
            ifid  = LATCH_RESET;
            idex  = LATCH_RESET;
            exmem = LATCH_RESET;
            memwb = LATCH_RESET;
        end else if (state == HALT || wb_halt) begin
            pcEn      = 1'b0;
            ifid      = LATCH_HOLD;
            idex      = LATCH_HOLD;
            exmem     = LATCH_HOLD;
            memwb     = LATCH_HOLD;
            haltedInt = 1'b1;
            nextState = HALT;
            nextPend  = ihitPend;
        end else if (dwait) begin
            // Freeze the front of the pipe, drain a bubble into WB.
            pcEn      = 1'b0;
            ifid      = LATCH_HOLD;
            idex      = LATCH_HOLD;
            exmem     = LATCH_HOLD;
            memwb     = LATCH_BUB;
            nextState = DWAIT;
            nextPend  = ihitPend | ihit;
        end else if (mem_branch) begin
            // Squash the three wrong-path instructions; pending fetch is wrong-path too.
            ifid  = LATCH_BUB;
            idex  = LATCH_BUB;
            exmem = LATCH_BUB;
        end else if (hu_stall) begin
            pcEn     = 1'b0;
            ifid     = LATCH_HOLD;
            idex     = LATCH_BUB;
            nextPend = ihitPend | ihit;
        end else if (!effIhit) begin
            pcEn = 1'b0;
            ifid = LATCH_BUB;
        end
    end

    // State and pending-fetch registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) begin
            state    <= RUN;
            ihitPend <= 1'b0;
        end else begin
            state    <= nextState;
            ihitPend <= nextPend;
        end
    end

    assign pc_en       = pcEn;
    assign ifid_en     = ifid.en;
    assign ifid_flush  = ifid.flush;
    assign idex_en     = idex.en;
    assign idex_flush  = idex.flush;
    assign exmem_en    = exmem.en;
    assign exmem_flush = exmem.flush;
    assign memwb_en    = memwb.en;
    assign memwb_flush = memwb.flush;
    assign halted      = haltedInt;
    assign ctrl_state  = state;

`ifdef PIPE_PERF_EN
    logic stallEvt, flushEvt;

    // Stalls count only while running/waiting; branch flushes only when actually taken.
    assign stallEvt = ~RST & ~haltedInt & ~pcEn;
    assign flushEvt = ~RST & ~haltedInt & ~dwait & mem_branch;

    pipe_perf_cnt uPerf (
        .CLK      (CLK),
        .RST      (RST),
        .stallInc (stallEvt),
        .flushInc (flushEvt),
        .stallCnt (stall_cnt),
        .flushCnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic,
// expected responses from a rule-level model queued and checked by a monitor.
// Counter checks are compiled only when PIPE_PERF_EN is defined.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, mem_dREN, mem_dWEN, hu_stall, mem_branch, wb_halt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .hu_stall(hu_stall),
        .mem_branch(mem_branch), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .ctrl_state(ctrl_state)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Expected response: {pc_en, ifid{en,fl}, idex{en,fl}, exmem{en,fl}, memwb{en,fl}, halted, state}
    typedef struct {
        logic [11:0] vec;
        logic [31:0] sc;
        logic [31:0] fc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state (value after the coming clock edge once updated).
    int          mState = 0;
    bit          mPend = 1'b0;
    logic [31:0] mStall = '0;
    logic [31:0] mFlush = '0;

    localparam bit [1:0] ADV = 2'b10, HLD = 2'b00, BUB = 2'b11, RBB = 2'b01;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the response, advance the model.
    task automatic apply(input bit rst, input bit ih, input bit dh, input bit rd, input bit wr,
                         input bit st, input bit br, input bit hl, input bit preload,
                         input string tag);
        exp_t     e;
        bit [1:0] c1, c2, c3, c4;
        bit       pc, isHalt, dw, effI;
        int       kind;
        @(posedge CLK);
        #1;
        RST = rst; ihit = ih; dhit = dh; mem_dREN = rd; mem_dWEN = wr;
        hu_stall = st; mem_branch = br; wb_halt = hl;
`ifdef PIPE_PERF_EN
        if (preload) begin
            force dut.uPerf.stallCnt = 32'hFFFF_FFFF;
            mStall = 32'hFFFF_FFFF;
        end
`endif
        dw     = (rd | wr) & !dh;
        effI   = ih | mPend;
        isHalt = 1'b0;
        if (rst)                     kind = 0;
        else if (mState == 2 || hl)  kind = 1;
        else if (dw)                 kind = 2;
        else if (br)                 kind = 3;
        else if (st)                 kind = 4;
        else if (!effI)              kind = 5;
        else                         kind = 6;
        case (kind)
            0:       begin pc = 0; c1 = RBB; c2 = RBB; c3 = RBB; c4 = RBB; end
            1:       begin pc = 0; c1 = HLD; c2 = HLD; c3 = HLD; c4 = HLD; isHalt = 1; end
            2:       begin pc = 0; c1 = HLD; c2 = HLD; c3 = HLD; c4 = BUB; end
            3:       begin pc = 1; c1 = BUB; c2 = BUB; c3 = BUB; c4 = ADV; end
            4:       begin pc = 0; c1 = HLD; c2 = BUB; c3 = ADV; c4 = ADV; end
            5:       begin pc = 0; c1 = BUB; c2 = ADV; c3 = ADV; c4 = ADV; end
            default: begin pc = 1; c1 = ADV; c2 = ADV; c3 = ADV; c4 = ADV; end
        endcase
        e.vec = {pc, c1, c2, c3, c4, isHalt, 2'(mState)};
        e.sc  = mStall;
        e.fc  = mFlush;
        e.tag = tag;
        sb.push_back(e);
        if (kind == 0) begin
            mState = 0; mPend = 0; mStall = '0; mFlush = '0;
        end else if (kind == 1) begin
            mState = 2;
        end else begin
            if (!pc)       mStall = mStall + 1;
            if (kind == 3) mFlush = mFlush + 1;
            mState = (kind == 2) ? 1 : 0;
            if (kind == 2 || kind == 4) mPend = mPend | ih;
            else                        mPend = 1'b0;
        end
`ifdef PIPE_PERF_EN
        if (preload) begin
            #3;
            release dut.uPerf.stallCnt;
        end
`endif
    endtask

    // Monitor: compare the DUT response on every falling edge against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                  exmem_en, exmem_flush, memwb_en, memwb_flush,
                                  halted, ctrl_state}), 32'(e.vec));
`ifdef PIPE_PERF_EN
                check({e.tag, " stall_cnt"}, stall_cnt, e.sc);
                check({e.tag, " flush_cnt"}, flush_cnt, e.fc);
`endif
            end
        end
    end

    initial begin
        RST = 1; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
        hu_stall = 0; mem_branch = 0; wb_halt = 0;

        //        rst ih dh rd wr st br hl pl
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, "normal");
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "fetch miss");

        // Data wait for three cycles, then dhit with ihit releases both.
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 0, 0, 0, 0, 0, "dwait");
        apply(0, 1, 1, 1, 0, 0, 0, 0, 0, "dwait exit");
        apply(0, 1, 0, 0, 1, 0, 0, 0, 0, "store wait");
        apply(0, 1, 1, 0, 1, 0, 0, 0, 0, "store done");

        // Load-use stall with ihit, then the pending fetch is used.
        apply(0, 1, 0, 0, 0, 1, 0, 0, 0, "hu_stall");
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "pend used");
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "pend gone");

        // Branch with stall and pending fetch: branch wins, pending fetch dropped.
        apply(0, 1, 0, 0, 0, 1, 0, 0, 0, "stall set pend");
        apply(0, 0, 0, 0, 0, 1, 1, 0, 0, "branch over stall");
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "pend cleared");

        // Halt arriving during a data wait, held despite dhit.
        apply(0, 1, 0, 1, 0, 0, 0, 0, 0, "pre-halt dwait");
        apply(0, 1, 0, 1, 0, 0, 0, 1, 0, "halt in dwait");
        for (int i = 0; i < 10; i++) apply(0, 1, 1, 1, 0, 0, 1, 0, 0, "halt hold");

        // Reset out of HALT and out of DWAIT.
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset from halt");
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0, "dwait again");
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0, "dwait again");
        apply(1, 1, 0, 1, 0, 0, 0, 0, 0, "reset in dwait");
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, "after reset");

        // Counter wrap: preload all-ones then one stall cycle.
        apply(0, 1, 0, 0, 0, 1, 0, 0, 1, "stall wrap");
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, "post wrap");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 59) == 0,
                  1'b0, "random");
        end

        @(negedge CLK);
        @(negedge CLK);
        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports: CLK in 1, clock (all state on rising edge); RST in 1, synchronous active-high reset.
REQ-002 ihit in 1 SHALL mean the instruction fetch completed this cycle.
REQ-003 dhit in 1 SHALL mean the data access completed this cycle.
REQ-004 mem_dREN / mem_dWEN in 1 each SHALL mean the MEM-stage instruction reads / writes memory.
REQ-005 hu_stall in 1 SHALL mean the load-use (or atomic) stall from the hazard unit.
REQ-006 mem_branch in 1 SHALL mean a taken branch or jump-register resolved in MEM.
REQ-007 wb_halt in 1 SHALL mean a halt instruction reached WB.
REQ-008 Latch controls SHALL be outputs, 1 bit each: pc_en; ifid_en, ifid_flush; idex_en, idex_flush; exmem_en, exmem_flush; memwb_en, memwb_flush.
REQ-009 halted out 1 SHALL mean the pipeline is stopped permanently.
REQ-010 ctrl_state out 2 SHALL carry the current FSM state.

Function
REQ-011 The FSM SHALL have states RUN=0, DWAIT=1, HALT=2; outputs are combinational from the inputs and registered state, with zero cycles of latency.
REQ-012 dwait SHALL be defined as (mem_dREN|mem_dWEN) & !dhit.
REQ-013 Priority SHALL be HALT > dwait > mem_branch > hu_stall > fetch miss.
REQ-014 HALT / wb_halt: all *_en=0, all flushes=0, halted=1; HALT is absorbing until RST.
REQ-015 dwait: pc, ifid, idex, exmem en=0; memwb_en=1 with memwb_flush=1 (bubble into WB); next state DWAIT.
REQ-016 DWAIT exits to RUN in the same cycle dhit=1; that cycle is a normal RUN cycle.
REQ-017 mem_branch (no dwait): all en=1; ifid_flush, idex_flush and exmem_flush=1.
REQ-018 hu_stall (no dwait/branch): pc_en=0, ifid_en=0, idex_flush=1, and the rest advance.
REQ-019 Fetch miss (effective ihit=0): pc_en=0, ifid_flush=1, and the rest advance.
REQ-020 A normal cycle SHALL drive all en=1 and all flush=0.
REQ-021 ihit_pend reg: set when ihit=1 while pc_en=0 due to dwait or hu_stall.
REQ-022 Effective ihit SHALL be ihit|ihit_pend; ihit_pend clears on the first cycle pc_en=1.
REQ-023 ihit_pend SHALL be cleared by mem_branch, because the pending fetch is wrong-path.
REQ-024 A flush SHALL dominate its en; the latch loads a bubble whenever flush=1.
REQ-025 ihit and dhit in the same cycle as dwait resolution SHALL both be honoured: PC advances and DWAIT exits.

Reset
REQ-026 On RST=1 at a clock edge: state=RUN, ihit_pend=0, counters=0.
REQ-027 While RST=1, outputs SHALL be: all en=0, all flush=1, halted=0.
REQ-028 Reset mid-DWAIT or in HALT SHALL return to RUN on the next edge.

Configuration
REQ-029 With PIPE_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] (cycles with pc_en=0 in RUN/DWAIT) and flush_cnt[31:0] (mem_branch cycles).
REQ-030 Both counters SHALL wrap at 2^32 and freeze in HALT.
REQ-031 Without PIPE_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-032 The ctrl_state_t enum (RUN/DWAIT/HALT, 2 bits) SHALL go in cpu_types_pkg.
REQ-033 The counters SHALL be one sub-module, pipe_perf_cnt, instantiated only under PIPE_PERF_EN.

Verification
REQ-034 Bench scenario 1: mem_dREN=1, dhit=0 for 3 cycles then 1 -> state DWAIT for 3 cycles, pc_en=0, memwb_flush=1; 4th cycle RUN, all en=1.
REQ-035 Bench scenario 2: hu_stall=1 for 1 cycle with ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1; next cycle ihit=0 yet pc_en=1 (ihit_pend used).
REQ-036 Bench scenario 3: mem_branch=1 with hu_stall=1 and ihit_pend=1 -> ifid/idex/exmem_flush=1, pc_en=1, ihit_pend cleared.
REQ-037 Bench scenario 4: wb_halt=1 during dwait -> halted=1, all en=0, state=2, held for 10 cycles despite dhit=1.
REQ-038 Bench scenario 5: RST=1 while in DWAIT -> next edge state=0, flushes=1 during reset.
REQ-039 Bench scenario 6 (PIPE_PERF_EN): preload stall_cnt=32'hFFFFFFFF, 1 stall cycle -> stall_cnt=0.
